bus_op_issuer: RTL and testbench

Buffers bus-operation requests (Read, Write, Modify, Invalidate) raised by the L2 cache controller and issues them one at a time on the system bus, using request/grant arbitration and ack/retry completion. It sits directly downstream of the controller's bus-operation calls: the controller pushes an op code and address, and this block owns all bus sequencing, retry backoff and completion reporting. There is no data path; line data moves on a separate channel.

---
 rtl/bus_op_pkg.sv | 36 +++
 rtl/bus_op_fifo.sv | 81 ++++++++
 rtl/bus_op_issuer.sv | 211 +++++++++++++++++++++
 tb/tb_bus_op_issuer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_op_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bus_op_pkg                                                       |
// | Brief   : Shared types for the bus-operation issuer (op codes, FSM, trace) |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package bus_op_pkg;

    typedef enum logic [1:0] {
        OP_R = 2'b00,
        OP_W = 2'b01,
        OP_M = 2'b10,
        OP_I = 2'b11
    } bus_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CMD  = 3'd2,
        S_WAIT = 3'd3,
        S_BACK = 3'd4
    } state_e;

    function automatic byte op_char(input bus_op_e op);
        byte c;
        case (op)
            OP_R:    c = "R";
            OP_W:    c = "W";
            OP_M:    c = "M";
            default: c = "I";
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_op_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bus_op_fifo                                                      |
// | Brief   : Request FIFO (op code + address) with occupancy count            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bus_op_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [WIDTH-1:0]   w_mem_d [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q;
    logic [c_PTR_W-1:0] w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q;
    logic [c_PTR_W-1:0] w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q;
    logic [c_CNT_W-1:0] w_count_d;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count_q == c_CNT_W'(DEPTH));
    assign o_empty = (r_count_q == '0);
    assign o_count = r_count_q;
    assign o_data  = r_mem_q[r_rd_ptr_q];

    // Protect the pointers against an overflowing push or underflowing pop.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_mem_d[r_wr_ptr_q] = i_data;
            w_wr_ptr_d          = r_wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/bus_op_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bus_op_issuer                                                    |
// | Brief   : Queues L2 bus ops and issues them with req/gnt and ack/retry;    |
// |           define BUS_OP_TRACE_EN to print a line per completed op.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bus_op_issuer
    import bus_op_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 4,
    parameter int BACKOFF   = 4,
    parameter int MAX_RETRY = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     bus_req,
    input  logic                     bus_gnt,
    output logic                     bus_valid,
    output logic [1:0]               bus_cmd,
    output logic [ADDR_W-1:0]        bus_addr,
    input  logic                     bus_ack,
    input  logic                     bus_retry,
    output logic                     done_valid,
    output logic [1:0]               done_op,
    output logic [ADDR_W-1:0]        done_addr,
    output logic                     done_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ENTRY_W = ADDR_W + 2;
    localparam int c_RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int c_BACK_W  = $clog2(BACKOFF + 1);

    logic [c_ENTRY_W-1:0] w_head;
    logic [1:0]           w_head_op;
    logic [ADDR_W-1:0]    w_head_addr;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    state_e               r_state_q;
    state_e               w_state_d;
    logic [c_BACK_W-1:0]  r_back_cnt_q;
    logic [c_BACK_W-1:0]  w_back_cnt_d;
    logic [c_RETRY_W-1:0] r_retry_cnt_q;
    logic [c_RETRY_W-1:0] w_retry_cnt_d;
    logic                 r_ready_en_q;
    logic                 r_bus_req_q;
    logic                 w_bus_req_d;
    logic                 r_bus_valid_q;
    logic                 w_bus_valid_d;
    logic [1:0]           r_bus_cmd_q;
    logic [1:0]           w_bus_cmd_d;
    logic [ADDR_W-1:0]    r_bus_addr_q;
    logic [ADDR_W-1:0]    w_bus_addr_d;
    logic                 r_done_valid_q;
    logic                 w_done_valid_d;
    logic [1:0]           r_done_op_q;
    logic [1:0]           w_done_op_d;
    logic [ADDR_W-1:0]    r_done_addr_q;
    logic [ADDR_W-1:0]    w_done_addr_d;
    logic                 r_done_err_q;
    logic                 w_done_err_d;

    // Ready is held low through reset and derived from the registered count,
    // so a pop in the same cycle never opens a slot for a push.
    assign req_ready = r_ready_en_q && !w_full;
    assign w_push    = req_valid && req_ready;

    bus_op_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({req_op, req_addr}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_op   = w_head[ADDR_W +: 2];
    assign w_head_addr = w_head[ADDR_W-1:0];

    always_comb begin
        w_state_d      = r_state_q;
        w_back_cnt_d   = r_back_cnt_q;
        w_retry_cnt_d  = r_retry_cnt_q;
        w_pop          = 1'b0;
        w_done_valid_d = 1'b0;
        w_done_op_d    = '0;
        w_done_addr_d  = '0;
        w_done_err_d   = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    w_state_d = S_CMD;
                end
            end
            S_CMD: begin
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus_retry) begin
                    if (r_retry_cnt_q == c_RETRY_W'(MAX_RETRY)) begin
                        w_pop          = 1'b1;
                        w_done_valid_d = 1'b1;
                        w_done_op_d    = w_head_op;
                        w_done_addr_d  = w_head_addr;
                        w_done_err_d   = 1'b1;
                        w_retry_cnt_d  = '0;
                        w_state_d      = S_IDLE;
                    end else begin
                        w_retry_cnt_d = r_retry_cnt_q + 1'b1;
                        w_back_cnt_d  = '0;
                        w_state_d     = S_BACK;
                    end
                end else if (bus_ack) begin
                    w_pop          = 1'b1;
                    w_done_valid_d = 1'b1;
                    w_done_op_d    = w_head_op;
                    w_done_addr_d  = w_head_addr;
                    w_retry_cnt_d  = '0;
                    w_state_d      = S_IDLE;
                end
            end
            S_BACK: begin
                if (r_back_cnt_q == c_BACK_W'(BACKOFF)) begin
                    w_state_d = S_REQ;
                end else begin
                    w_back_cnt_d = r_back_cnt_q + 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Bus outputs are registered images of the next state.
        w_bus_req_d   = (w_state_d == S_REQ) || (w_state_d == S_CMD) || (w_state_d == S_WAIT);
        w_bus_valid_d = (w_state_d == S_CMD);
        w_bus_cmd_d   = w_bus_valid_d ? w_head_op : 2'b00;
        w_bus_addr_d  = w_bus_valid_d ? w_head_addr : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_back_cnt_q   <= '0;
            r_retry_cnt_q  <= '0;
            r_ready_en_q   <= 1'b0;
            r_bus_req_q    <= 1'b0;
            r_bus_valid_q  <= 1'b0;
            r_bus_cmd_q    <= '0;
            r_bus_addr_q   <= '0;
            r_done_valid_q <= 1'b0;
            r_done_op_q    <= '0;
            r_done_addr_q  <= '0;
            r_done_err_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_back_cnt_q   <= w_back_cnt_d;
            r_retry_cnt_q  <= w_retry_cnt_d;
            r_ready_en_q   <= 1'b1;
            r_bus_req_q    <= w_bus_req_d;
            r_bus_valid_q  <= w_bus_valid_d;
            r_bus_cmd_q    <= w_bus_cmd_d;
            r_bus_addr_q   <= w_bus_addr_d;
            r_done_valid_q <= w_done_valid_d;
            r_done_op_q    <= w_done_op_d;
            r_done_addr_q  <= w_done_addr_d;
            r_done_err_q   <= w_done_err_d;
        end
    end

    assign bus_req    = r_bus_req_q;
    assign bus_valid  = r_bus_valid_q;
    assign bus_cmd    = r_bus_cmd_q;
    assign bus_addr   = r_bus_addr_q;
    assign done_valid = r_done_valid_q;
    assign done_op    = r_done_op_q;
    assign done_addr  = r_done_addr_q;
    assign done_err   = r_done_err_q;

`ifdef BUS_OP_TRACE_EN
    always @(posedge clk) begin
        if (r_done_valid_q) begin
            $display("%c %h%s", op_char(bus_op_e'(r_done_op_q)), r_done_addr_q,
                     r_done_err_q ? " ERR" : "");
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_op_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bus_op_issuer                                                 |
// | Brief   : Scoreboard bench for bus_op_issuer with scripted ack/retry agent |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bus_op_issuer;
    import bus_op_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 4;
    localparam int BACKOFF   = 4;
    localparam int MAX_RETRY = 7;
    localparam int HIST_N    = 8192;

    localparam logic [1:0] RSP_ACK   = 2'd0;
    localparam logic [1:0] RSP_RETRY = 2'd1;
    localparam logic [1:0] RSP_BOTH  = 2'd2;
    localparam logic [1:0] RSP_NONE  = 2'd3;

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [1:0]            req_op = 2'b00;
    logic [ADDR_W-1:0]     req_addr = '0;
    logic                  bus_req;
    logic                  bus_gnt;
    logic                  bus_valid;
    logic [1:0]            bus_cmd;
    logic [ADDR_W-1:0]     bus_addr;
    logic                  bus_ack = 1'b0;
    logic                  bus_retry = 1'b0;
    logic                  done_valid;
    logic [1:0]            done_op;
    logic [ADDR_W-1:0]     done_addr;
    logic                  done_err;
    logic [$clog2(DEPTH):0] count;

    logic                  gnt_en = 1'b0;
    logic                  pend_v = 1'b0;
    logic [1:0]            pend_rsp = RSP_ACK;
    exp_t                  sb_q[$];
    logic [1:0]            rsp_q[$];
    exp_t                  e_mon;
    int                    t_valid[$];
    logic                  req_hist [HIST_N];
    int                    n_chk = 0;
    int                    n_err = 0;
    int                    cyc = 0;
    int                    n_valid = 0;
    int                    n_done = 0;
    int                    t_done_last = 0;
    int                    t_push = 0;
    int                    t0 = 0;
    int                    r_edge = 0;
    logic                  acc;

    assign bus_gnt = gnt_en;

    bus_op_issuer #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BACKOFF   (BACKOFF),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_valid  (bus_valid),
        .bus_cmd    (bus_cmd),
        .bus_addr   (bus_addr),
        .bus_ack    (bus_ack),
        .bus_retry  (bus_retry),
        .done_valid (done_valid),
        .done_op    (done_op),
        .done_addr  (done_addr),
        .done_err   (done_err),
        .count      (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic err, output logic accepted);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        accepted  = req_ready;
        if (accepted) sb_q.push_back('{op, addr, err});
        @(posedge clk);
        #1;
        t_push    = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("done_count", n_done, target);
    endtask

    task automatic clear_stats();
        n_valid = 0;
        n_done  = 0;
        t_valid.delete();
    endtask

    // Monitor and bus agent: scoreboard compares, then drives the scripted
    // response during the WAIT cycle that follows each command strobe.
    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (cyc < HIST_N) req_hist[cyc] = bus_req;
            if (bus_valid) begin
                n_valid++;
                t_valid.push_back(cyc);
                check("valid_sb", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    check("bus_cmd", bus_cmd, sb_q[0].op);
                    check("bus_addr", bus_addr, sb_q[0].addr);
                end
            end else begin
                check("cmd_idle_zero", {bus_cmd, bus_addr}, 0);
            end
            if (done_valid) begin
                n_done++;
                t_done_last = cyc;
                check("done_sb", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e_mon = sb_q.pop_front();
                    check("done_op", done_op, e_mon.op);
                    check("done_addr", done_addr, e_mon.addr);
                    check("done_err", done_err, e_mon.err);
                end
            end
            bus_ack   = 1'b0;
            bus_retry = 1'b0;
            if (rst) begin
                pend_v = 1'b0;
            end else if (pend_v) begin
                bus_ack   = (pend_rsp == RSP_ACK) || (pend_rsp == RSP_BOTH);
                bus_retry = (pend_rsp == RSP_RETRY) || (pend_rsp == RSP_BOTH);
                pend_v    = 1'b0;
            end
            if (bus_valid && !rst) begin
                pend_v   = 1'b1;
                pend_rsp = (rsp_q.size() != 0) ? rsp_q.pop_front() : RSP_ACK;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", req_ready, 1);

        // Single read, immediate grant and ack
        gnt_en = 1'b1;
        clear_stats();
        push(2'b00, 32'h0000_1000, 1'b0, acc);
        t0 = t_push;
        check("single_count", count, 1);
        wait_done(1, 50);
        check("single_req_n1", req_hist[t0 + 1], 1);
        check("single_valid_lat", t_valid[0] - t0, 2);
        check("single_done_lat", t_done_last - t0, 4);
        check("single_nvalid", n_valid, 1);
        @(posedge clk);
        #2;
        check("single_count_end", count, 0);

        // Fill with grant withheld; fifth push is refused
        gnt_en = 1'b0;
        clear_stats();
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            push(2'((i + 1) % 4), 32'h100 * (i + 1), 1'b0, acc);
            check("fill_accept", acc, (i < 4) ? 1 : 0);
        end
        check("fill_count", count, 4);
        check("fill_ready", req_ready, 0);
        gnt_en = 1'b1;
        wait_done(4, 200);
        check("fill_nvalid", n_valid, 4);

        // Single retry then ack: backoff spacing on bus_req
        clear_stats();
        repeat (2) @(posedge clk);
        rsp_q.push_back(RSP_RETRY);
        rsp_q.push_back(RSP_ACK);
        push(2'b10, 32'h0000_2040, 1'b0, acc);
        wait_done(1, 100);
        check("retry_nvalid", n_valid, 2);
        if (t_valid.size() >= 2) begin
            r_edge = t_valid[0] + 2;
            for (int k = 0; k <= BACKOFF; k++) begin
                check("retry_req_low", req_hist[r_edge + k], 0);
            end
            check("retry_req_back", req_hist[r_edge + BACKOFF + 1], 1);
            check("retry_revalid", t_valid[1] - r_edge, BACKOFF + 2);
        end

        // Retry exhaustion, then a follow-up op that itself retries once
        clear_stats();
        repeat (2) @(posedge clk);
        for (int k = 0; k <= MAX_RETRY; k++) rsp_q.push_back(RSP_RETRY);
        rsp_q.push_back(RSP_RETRY);
        rsp_q.push_back(RSP_ACK);
        push(2'b11, 32'h0000_3000, 1'b1, acc);
        push(2'b00, 32'h0000_3100, 1'b0, acc);
        wait_done(2, 600);
        check("exhaust_nvalid", n_valid, MAX_RETRY + 1 + 2);

        // Ack and retry together behaves as retry
        clear_stats();
        repeat (2) @(posedge clk);
        rsp_q.push_back(RSP_BOTH);
        rsp_q.push_back(RSP_ACK);
        push(2'b01, 32'h0000_4000, 1'b0, acc);
        wait_done(1, 100);
        check("both_nvalid", n_valid, 2);
        if (t_valid.size() >= 2) check("both_done_after_2nd", t_done_last > t_valid[1], 1);

        // Reset while waiting on the bus with three ops queued
        clear_stats();
        repeat (2) @(posedge clk);
        rsp_q.push_back(RSP_NONE);
        push(2'b00, 32'h0000_6000, 1'b0, acc);
        push(2'b01, 32'h0000_6100, 1'b0, acc);
        push(2'b10, 32'h0000_6200, 1'b0, acc);
        for (int k = 0; k < 50 && n_valid == 0; k++) begin
            @(posedge clk);
            #2;
        end
        check("rstmid_issued", n_valid, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        sb_q.delete();
        rsp_q.delete();
        check("rstmid_bus_req", bus_req, 0);
        check("rstmid_bus_valid", bus_valid, 0);
        check("rstmid_bus_cmd_addr", {bus_cmd, bus_addr}, 0);
        check("rstmid_done", {done_valid, done_err, done_op, done_addr}, 0);
        check("rstmid_ready", req_ready, 0);
        check("rstmid_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rstmid_no_done", n_done, 0);
        check("rstmid_count_idle", count, 0);
        push(2'b00, 32'h0000_5000, 1'b0, acc);
        check("rstmid_push_acc", acc, 1);
        wait_done(1, 50);

        repeat (3) @(posedge clk);
        #2;
        check("final_sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
